// File: rtl/stepgen_cmd_sched.sv
// stepgen_cmd_sched: frame-atomic command scheduler for four stepgen axes.
// Shadows SPI writes, commits on tick, snapshots positions, velocity timeout.
module stepgen_cmd_sched #(
   parameter int W   = 10,
   parameter int F   = 11,
   parameter int T   = 4,
   parameter int O   = 14,
   parameter int TMO = 2048
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick,
   input  logic                 frame_start,
   input  logic                 frame_end,
   input  logic                 wr_en,
   input  logic [2:0]           wr_addr,
   input  logic [15:0]          wr_data,
   input  logic [4*(W+F)-1:0]   pos_in,
   output logic [4*(W+F)-1:0]   snap_pos,
   output logic [4*(F+1)-1:0]   vel_out,
   output logic [O-1:0]         dout,
   output logic [T-1:0]         dirtime,
   output logic [T-1:0]         steptime,
   output logic [1:0]           tap,
   output logic                 spolarity,
   output logic                 commit,
   output logic                 timed_out
);

   localparam int CW = $clog2(TMO + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(TMO);
   localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);

   typedef enum logic [1:0] {
      IDLE,
      RX,
      PEND
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [5:0]      dirty;
   logic [5:0]      dirty_nxt;
   logic            snap_now;
   logic            commit_now;
   logic            wr_ok;

   logic [3:0][F:0] sh_vel;
   logic [O-1:0]    sh_dout;
   logic [T-1:0]    sh_dirtime;
   logic [T-1:0]    sh_steptime;
   logic            sh_spol;
   logic [1:0]      sh_tap;

   logic [3:0][F:0] vel_q;
   logic [CW-1:0]   tick_cnt;

   // Some data bits carry no field in any register.
   logic            unused_wr;
   assign unused_wr = ^wr_data;

   assign vel_out = vel_q;

   // Frame state and dirty-mask registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         dirty <= '0;
      end else begin
         state <= state_nxt;
         dirty <= dirty_nxt;
      end
   end

   // Next state: frame tracking, write acceptance, commit and snapshot.
   always_comb begin
      state_nxt  = state;
      dirty_nxt  = dirty;
      snap_now   = 1'b0;
      commit_now = 1'b0;
      wr_ok      = 1'b0;
      unique case (state)
         IDLE: begin
            if (frame_start) begin
               snap_now  = 1'b1;
               dirty_nxt = '0;
               state_nxt = RX;
            end
         end
         RX: begin
            if (frame_start) begin
               // aborted frame: drop what it wrote, restart
               snap_now  = 1'b1;
               dirty_nxt = '0;
            end else begin
               if (wr_en && (wr_addr <= 3'd5)) begin
                  wr_ok     = 1'b1;
                  dirty_nxt = dirty | (6'b1 << wr_addr);
               end
               if (frame_end) begin
                  state_nxt = (dirty_nxt != '0) ? PEND : IDLE;
               end
            end
         end
         PEND: begin
            if (frame_start) begin
               // flush the pending frame before the next one
               commit_now = 1'b1;
               snap_now   = 1'b1;
               dirty_nxt  = '0;
               state_nxt  = RX;
            end else if (tick) begin
               commit_now = 1'b1;
               state_nxt  = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Shadow registers capture accepted writes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_vel      <= '0;
         sh_dout     <= '0;
         sh_dirtime  <= '0;
         sh_steptime <= '0;
         sh_spol     <= 1'b0;
         sh_tap      <= '0;
      end else if (wr_ok) begin
         unique case (wr_addr)
            3'd0, 3'd1, 3'd2, 3'd3: begin
               sh_vel[wr_addr[1:0]] <= wr_data[F:0];
            end
            3'd4: begin
               sh_dout <= wr_data[O-1:0];
            end
            3'd5: begin
               sh_dirtime  <= wr_data[T-1:0];
               sh_spol     <= wr_data[7];
               sh_steptime <= wr_data[T+7:8];
               sh_tap      <= wr_data[15:14];
            end
            default: begin
            end
         endcase
      end
   end

   // Position snapshot at every frame start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap_pos <= '0;
      end else if (snap_now) begin
         snap_pos <= pos_in;
      end
   end

   // Active registers: dirty-only commit, tick counter and timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vel_q     <= '0;
         dout      <= '0;
         dirtime   <= '0;
         steptime  <= '0;
         tap       <= '0;
         spolarity <= 1'b0;
         commit    <= 1'b0;
         timed_out <= 1'b1;
         tick_cnt  <= '0;
      end else begin
         commit <= commit_now;
         if (commit_now) begin
            // commit wins over a coincident expiry
            for (int n = 0; n < 4; n++) begin
               if (dirty[n]) begin
                  vel_q[n] <= sh_vel[n];
               end
            end
            if (dirty[4]) begin
               dout <= sh_dout;
            end
            if (dirty[5]) begin
               dirtime   <= sh_dirtime;
               steptime  <= sh_steptime;
               tap       <= sh_tap;
               spolarity <= sh_spol;
            end
            tick_cnt  <= '0;
            timed_out <= 1'b0;
         end else if (tick && (tick_cnt != CNT_MAX)) begin
            tick_cnt <= tick_cnt + 1'b1;
            if (tick_cnt == CNT_LAST) begin
               vel_q     <= '0;
               timed_out <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/stepgen_cmd_sched.md
# stepgen_cmd_sched

Command scheduler between the SPI byte decoder and the four stepgen channels. Buffers register writes from one SPI frame in shadow registers and commits them atomically on the next stepgen tick, so all axes change velocity together. Snapshots axis positions at frame start for a coherent readback, and zeroes velocities if no commit arrives within a tick timeout.

## Interface
Parameters:
- W, 10, position integer width
- F, 11, velocity fraction width; velocity registers are F+1 bits
- T, 4, dirtime/steptime width
- O, 14, digital output width
- TMO, 2048, timeout in ticks; must be at least 2

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tick  in  1  stepgen tick strobe, one clk wide (stepcnt)
- frame_start  in  1  synchronized SSEL falling-edge pulse
- frame_end  in  1  synchronized SSEL rising-edge pulse
- wr_en  in  1  write strobe from byte decoder
- wr_addr  in  3  register index: 0–3 = vel0–vel3, 4 = dout, 5 = timing cfg, 6–7 = ignored
- wr_data  in  16  write data
- pos_in  in  4*(W+F)  live stepgen positions, axis0 in the LSBs
- snap_pos  out  4*(W+F)  position snapshot taken at frame start
- vel_out  out  4*(F+1)  active velocities, axis0 in the LSBs
- dout  out  O  active digital outputs
- dirtime  out  T  active direction setup time
- steptime  out  T  active step time
- tap  out  2  active tap
- spolarity  out  1  step polarity
- commit  out  1  one-cycle pulse when active registers update
- timed_out  out  1  set when the timeout has expired

## Operation
- States: IDLE, RX, PEND. Reset state is IDLE.
- Reset values:
  - All outputs 0, except timed_out = 1.
  - Shadow registers 0, dirty mask 0, tick counter 0.
- IDLE:
  - frame_start: snap_pos <= pos_in; dirty mask cleared; go to RX.
- RX:
  - wr_en with addr 0–5 writes shadow[addr] and sets dirty[addr]. Addr 6–7 is dropped.
  - frame_end: go to PEND if dirty is nonzero, else go to IDLE.
  - frame_start while in RX (aborted frame): discard the dirty mask, re-snapshot, stay in RX.
  - wr_en and frame_end in the same cycle: the write is accepted before the dirty check.
- PEND:
  - tick: commit, go to IDLE.
  - frame_start (with or without tick): commit, snapshot, clear dirty, go to RX. The pending frame is never lost.
  - wr_en in PEND or IDLE is ignored.
- Commit copies only the dirty shadow registers to the active registers:
  - vel[n] <= wr_data[F:0]
  - dout <= wr_data[O-1:0]
  - cfg: dirtime <= [T-1:0], spolarity <= [7], steptime <= [T+7:8], tap <= [15:14]
  - Commit also clears the tick counter and timed_out.
- Timeout:
  - The tick counter increments on each tick and saturates at TMO.
  - When the counter reaches TMO: all four vel_out are forced to 0 and timed_out = 1.
  - dout and cfg retain their values.
  - A commit in the same cycle as the expiry wins: the committed values apply and the counter resets.

## Timing
- Write to shadow: shadow updated at the clock edge that samples wr_en.
- Commit: tick (or frame_start) sampled in PEND in cycle k. Active outputs and commit=1 are visible in cycle k+1. commit deasserts in cycle k+2.
- Snapshot: snap_pos holds pos_in as sampled in the frame_start cycle. It is stable for the whole frame.
- Timeout: the tick that brings the counter to TMO zeroes vel_out one cycle later.
- rst asserted mid-frame or while in PEND: immediate return to reset values; no commit is issued.
- Throughput: one write per cycle maximum. Back-to-back frames are supported with no gap cycles.

## Test plan
- Reset then idle:
  - Stimulus: release rst, hold all inputs 0.
  - Required: vel_out = 0, timed_out = 1, commit never pulses.
- Atomic commit:
  - Stimulus: frame with writes vel0=0x123, vel3=0x7FF, then frame_end; tick 20 cycles later.
  - Required: vel_out unchanged until the cycle after the tick, then both values appear together. commit is high for 1 cycle; timed_out becomes 0.
- Partial/empty frame:
  - Stimulus: frame with only a write to addr 6, then frame_end, then tick.
  - Required: returns to IDLE, no commit, outputs unchanged.
- Frame_start during PEND:
  - Stimulus: frame writes dout=0x2AAA, frame_end, then frame_start before any tick.
  - Required: dout=0x2AAA and commit pulse on the next cycle; snap_pos equals pos_in from that cycle; new frame proceeds.
- Timeout:
  - Stimulus: commit vel1=0x400, then send TMO ticks with no frames.
  - Required: vel1 drops to 0 one cycle after the TMO-th tick, timed_out=1, dout/cfg retained. A subsequent commit restores the new values.
- Cfg decode and async reset mid-frame:
  - Stimulus: write cfg=0xC385.
  - Required: after commit, tap=3, steptime=3, spolarity=1, dirtime=5.
  - Stimulus: then pulse rst during RX.
  - Required: outputs return to reset values immediately.
